// File: rtl/noc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_fifo_pkg
// Brief    : Shared constants, flit type and width helper for the VC input buffer.
// Revision : 1.0 - initial release
// ============================================================================
package noc_fifo_pkg;

    // Channel-select width: a single channel still needs a 1-bit select port.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int C_FLIT_W   = 16;
    localparam int C_DEF_DEPTH  = 4;
    localparam int C_DEF_NUM_VC = 2;

    localparam int VC_W  = clog2_min1(C_DEF_NUM_VC);
    localparam int CNT_W = $clog2(C_DEF_DEPTH + 1);

    typedef logic [C_FLIT_W-1:0] flit_t;

endpackage
`default_nettype wire

// File: rtl/fifo_channel.sv
`default_nettype none
// ============================================================================
// Module   : fifo_channel
// Brief    : Single virtual-channel FIFO: storage, pointers, count and flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_channel #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = DEPTH - 1,
    localparam int c_ptr_w   = $clog2(DEPTH),
    localparam int c_cnt_w   = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] head,
    output logic [c_cnt_w-1:0]    count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af_thr = c_cnt_w'(AF_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head        = r_mem[r_rd_ptr];
    assign count       = r_count;
    assign full        = (r_count == c_depth);
    assign empty       = (r_count == '0);
    assign almost_full = (r_count >= c_af_thr);

endmodule
`default_nettype wire

// File: rtl/vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo
// Brief    : Multi-VC router input buffer with shared write/read ports.
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo
    import noc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(flit_t),
    parameter int DEPTH      = 4,
    parameter int NUM_VC     = 2,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int FWFT       = 1,
    localparam int c_vc_w    = clog2_min1(NUM_VC),
    localparam int c_cnt_w   = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [c_vc_w-1:0]           wr_vc,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    input  logic [c_vc_w-1:0]           rd_vc,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic [NUM_VC-1:0]           full,
    output logic [NUM_VC-1:0]           empty,
    output logic [NUM_VC-1:0]           almost_full,
    output logic [NUM_VC*c_cnt_w-1:0]   count,
    output logic                        wr_err,
    output logic                        rd_err
);

    localparam logic [c_vc_w:0] c_num_vc = (c_vc_w + 1)'(NUM_VC);

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_rd_avail;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic [NUM_VC-1:0]     w_push;
    logic [NUM_VC-1:0]     w_pop;
    logic [DATA_WIDTH-1:0] w_head [NUM_VC];
    logic [DATA_WIDTH-1:0] w_head_sel;
    logic                  r_wr_err;
    logic                  r_rd_err;

    assign w_wr_in_range = ({1'b0, wr_vc} < c_num_vc);
    assign w_rd_in_range = ({1'b0, rd_vc} < c_num_vc);
    assign w_rd_avail    = w_rd_in_range && !empty[rd_vc];
    assign w_rd_ok       = rd_en && w_rd_avail;
    // A full channel still takes a write when the same cycle frees a slot.
    assign w_wr_ok       = wr_en && w_wr_in_range &&
                           (!full[wr_vc] || (w_rd_ok && (rd_vc == wr_vc)));

    always_comb begin
        w_push     = '0;
        w_pop      = '0;
        w_head_sel = '0;
        if (w_wr_ok) begin
            w_push[wr_vc] = 1'b1;
        end
        if (w_rd_ok) begin
            w_pop[rd_vc] = 1'b1;
        end
        if (w_rd_avail) begin
            w_head_sel = w_head[rd_vc];
        end
    end

    for (genvar k = 0; k < NUM_VC; k++) begin : g_vc
        fifo_channel #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .AF_THRESH  (AF_THRESH)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .push        (w_push[k]),
            .pop         (w_pop[k]),
            .wr_data     (wr_data),
            .head        (w_head[k]),
            .count       (count[k*c_cnt_w +: c_cnt_w]),
            .full        (full[k]),
            .empty       (empty[k]),
            .almost_full (almost_full[k])
        );
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_valid = w_rd_avail;
        assign rd_data  = w_head_sel;
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] r_rd_data;
        logic                  r_rd_valid;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_rd_ok;
                if (w_rd_ok) begin
                    r_rd_data <= w_head_sel;
                end
            end
        end

        assign rd_valid = r_rd_valid;
        assign rd_data  = r_rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_err <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_wr_ok;
            r_rd_err <= rd_en && !w_rd_ok;
        end
    end

    assign wr_err = r_wr_err;
    assign rd_err = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_vc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_fifo
// Brief    : Scoreboard bench driving an FWFT and a registered-read instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_fifo;
    import noc_fifo_pkg::*;

    localparam int DW = 16;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [0:0]    wr_vc;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [0:0]    rd_vc;

    logic [DW-1:0] f_rd_data, r_rd_data;
    logic          f_rd_valid, r_rd_valid;
    logic [1:0]    f_full, f_empty, f_af, r_full, r_empty, r_af;
    logic [2*CW-1:0] f_count, r_count;
    logic          f_wr_err, f_rd_err, r_wr_err, r_rd_err;

    typedef struct packed {
        logic    vld;
        flit_t   data;
    } exp_t;

    exp_t q_f[$];
    exp_t q_r[$];
    exp_t ef, er;
    logic pend;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vc_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .NUM_VC(2), .AF_THRESH(3), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(f_rd_data), .rd_valid(f_rd_valid),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .count(f_count),
        .wr_err(f_wr_err), .rd_err(f_rd_err)
    );

    vc_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .NUM_VC(2), .AF_THRESH(3), .FWFT(0)) dut_r (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_vc(wr_vc), .wr_data(wr_data),
        .rd_en(rd_en), .rd_vc(rd_vc), .rd_data(r_rd_data), .rd_valid(r_rd_valid),
        .full(r_full), .empty(r_empty), .almost_full(r_af), .count(r_count),
        .wr_err(r_wr_err), .rd_err(r_rd_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // One clock of stimulus; a read records its expected outcome for both monitors.
    task automatic step(input logic w, input logic wv, input logic [DW-1:0] wd,
                        input logic r, input logic rv, input logic ev, input logic [DW-1:0] ed);
        wr_en   = w;
        wr_vc   = wv;
        wr_data = wd;
        rd_en   = r;
        rd_vc   = rv;
        if (r) begin
            q_f.push_back({ev, ed});
            q_r.push_back({ev, ed});
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic vc, input logic [DW-1:0] d);
        step(1'b1, vc, d, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input logic vc, input logic ev, input logic [DW-1:0] ed);
        step(1'b0, 1'b0, '0, 1'b1, vc, ev, ed);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_f_count"}, 32'(f_count), 32'h0);
        chk({tag, "_r_count"}, 32'(r_count), 32'h0);
        chk({tag, "_f_empty"}, 32'(f_empty), 32'h3);
        chk({tag, "_f_full"},  32'(f_full),  32'h0);
        chk({tag, "_f_af"},    32'(f_af),    32'h0);
        chk({tag, "_errs"},    {28'h0, f_wr_err, f_rd_err, r_wr_err, r_rd_err}, 32'h0);
        chk({tag, "_f_rd"},    {15'h0, f_rd_valid, f_rd_data}, 32'h0);
        chk({tag, "_r_rd"},    {15'h0, r_rd_valid, r_rd_data}, 32'h0);
    endtask

    // FWFT instance: the popped flit is visible in the same cycle as rd_en.
    always @(negedge clk) begin
        if (rst && rd_en) begin
            if (q_f.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fwft_queue actual=empty required=entry");
            end else begin
                ef = q_f.pop_front();
                chk("fwft_rd_valid", 32'(f_rd_valid), 32'(ef.vld));
                if (ef.vld) chk("fwft_rd_data", 32'(f_rd_data), 32'(ef.data));
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) pend <= 1'b0;
        else      pend <= rd_en;
    end

    // Registered instance: result appears one cycle after the read request.
    always @(negedge clk) begin
        if (rst) begin
            if (pend) begin
                if (q_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL reg_queue actual=empty required=entry");
                end else begin
                    er = q_r.pop_front();
                    chk("reg_rd_valid", 32'(r_rd_valid), 32'(er.vld));
                    if (er.vld) chk("reg_rd_data", 32'(r_rd_data), 32'(er.data));
                end
            end else begin
                chk("reg_rd_valid_idle", 32'(r_rd_valid), 32'h0);
            end
        end
    end

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_vc = '0; wr_data = '0; rd_en = 1'b0; rd_vc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("init");
        rst = 1'b1;

        // Fill VC0, watch count and flags climb, then overflow.
        wr(1'b0, 16'h0001); chk("t1_cnt1", 32'(f_count[2:0]), 32'd1); chk("t1_af1", 32'(f_af), 32'h0);
        wr(1'b0, 16'h0002); chk("t1_cnt2", 32'(f_count[2:0]), 32'd2); chk("t1_af2", 32'(f_af), 32'h0);
        wr(1'b0, 16'h0003); chk("t1_cnt3", 32'(f_count[2:0]), 32'd3); chk("t1_af3", 32'(f_af), 32'h1);
        chk("t1_full3", 32'(f_full), 32'h0);
        wr(1'b0, 16'h0004); chk("t1_cnt4", 32'(f_count[2:0]), 32'd4); chk("t1_full4", 32'(f_full), 32'h1);
        chk("t1_empty", 32'(f_empty), 32'h2);
        chk("t1_vc1_cnt", 32'(f_count[5:3]), 32'd0);
        wr(1'b0, 16'h00FF);
        chk("t1_wr_err", {31'h0, f_wr_err}, 32'h1);
        chk("t1_r_wr_err", {31'h0, r_wr_err}, 32'h1);
        chk("t1_cnt_hold", 32'(f_count[2:0]), 32'd4);
        idle();
        chk("t1_wr_err_pulse", {31'h0, f_wr_err}, 32'h0);
        rd_vc = 1'b0;
        #1;
        chk("t1_peek", {15'h0, f_rd_valid, f_rd_data}, {15'h0, 1'b1, 16'h0001});

        // Full channel: simultaneous write and pop, then drain across the wrap.
        step(1'b1, 1'b0, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0001);
        chk("t2_no_wr_err", {31'h0, f_wr_err}, 32'h0);
        chk("t2_cnt", 32'(f_count[2:0]), 32'd4);
        chk("t2_r_cnt", 32'(r_count[2:0]), 32'd4);
        rd(1'b0, 1'b1, 16'h0002);
        rd(1'b0, 1'b1, 16'h0003);
        rd(1'b0, 1'b1, 16'h0004);
        rd(1'b0, 1'b1, 16'h0005);
        chk("t2_empty", 32'(f_empty), 32'h3);

        // Interleaved channels keep their own order.
        wr(1'b0, 16'h00A0);
        wr(1'b1, 16'h00B0);
        wr(1'b0, 16'h00A1);
        chk("t3_counts", 32'(f_count), {26'h0, 3'd1, 3'd2});
        rd(1'b1, 1'b1, 16'h00B0);
        rd(1'b0, 1'b1, 16'h00A0);
        rd(1'b0, 1'b1, 16'h00A1);

        // Empty-channel pop with same-cycle write: rejected, no bypass.
        step(1'b1, 1'b1, 16'h00C0, 1'b1, 1'b1, 1'b0, '0);
        chk("t4_rd_err", {31'h0, f_rd_err}, 32'h1);
        chk("t4_r_rd_err", {31'h0, r_rd_err}, 32'h1);
        chk("t4_cnt1", 32'(f_count[5:3]), 32'd1);
        rd(1'b1, 1'b1, 16'h00C0);
        chk("t4_rd_err_pulse", {31'h0, f_rd_err}, 32'h0);

        // Back-to-back pops.
        wr(1'b0, 16'h1234);
        wr(1'b0, 16'h5678);
        rd(1'b0, 1'b1, 16'h1234);
        rd(1'b0, 1'b1, 16'h5678);
        idle();
        idle();

        // Asynchronous reset mid-cycle with VC0 at count 3.
        wr(1'b0, 16'h0011);
        wr(1'b0, 16'h0022);
        wr(1'b0, 16'h0033);
        chk("t6_cnt3", 32'(f_count[2:0]), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check_reset("t6");
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr(1'b0, 16'h0009);
        chk("t6_cnt_after", 32'(f_count[2:0]), 32'd1);
        rd(1'b0, 1'b1, 16'h0009);
        idle();
        idle();

        chk("fwft_drained", 32'(q_f.size()), 32'd0);
        chk("reg_drained", 32'(q_r.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_fifo.md
Name: vc_fifo

Overview:
Parametrised multi-channel input buffer for a NoC router port: NUM_VC independent FIFOs (virtual channels) share one write port and one read port. Each channel has its own pointers, count, full/empty/almost_full flags, and error reporting. Read mode is selectable at elaboration time: first-word-fall-through or registered. Sits between the link receiver and the router's VC allocator / switch arbiter.

Parameters:
DATA_WIDTH, 16, flit width in bits
DEPTH, 4, entries per channel; power of two, >= 2
NUM_VC, 2, number of channels; >= 1
AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH; range 1..DEPTH
FWFT, 1, 1 = combinational head read; 0 = registered read with 1-cycle latency

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
wr_en  in  1  write request
wr_vc  in  VC_W  target channel for the write; VC_W = max(1, clog2(NUM_VC))
wr_data  in  DATA_WIDTH  write flit
rd_en  in  1  read (pop) request
rd_vc  in  VC_W  source channel for the read
rd_data  out  DATA_WIDTH  read flit
rd_valid  out  1  rd_data is valid
full  out  NUM_VC  per-channel full flag
empty  out  NUM_VC  per-channel empty flag
almost_full  out  NUM_VC  per-channel threshold flag
count  out  NUM_VC*CNT_W  per-channel occupancy, packed; channel k at [k*CNT_W +: CNT_W]; CNT_W = clog2(DEPTH+1)
wr_err  out  1  registered pulse: the previous cycle's write was dropped
rd_err  out  1  registered pulse: the previous cycle's read was invalid

Behaviour:
- Reset (rst = 0, asynchronous assert, synchronous-safe deassert):
  - All pointers and counts go to 0; empty = all 1; full, almost_full = all 0.
  - wr_err = rd_err = rd_valid = 0; rd_data = 0.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued flits; the first write after deassert lands at index 0.
- Flags are pure decodes of count: full = (count == DEPTH), empty = (count == 0), almost_full = (count >= AF_THRESH).
- Write accept rule: wr_en && wr_vc < NUM_VC && (!full[wr_vc] || pop of the same channel in this cycle).
  - An accepted write stores the flit at the channel's wr_ptr and increments the pointer modulo DEPTH.
  - A rejected write leaves all state unchanged, and wr_err = 1 in the next cycle.
- Read accept rule (pop): rd_en && rd_vc < NUM_VC && !empty[rd_vc].
  - An accepted pop increments rd_ptr modulo DEPTH.
  - A rejected read leaves state unchanged, and rd_err = 1 in the next cycle.
  - A read of an empty channel is rejected even if the same cycle writes that channel; there is no bypass.
- Count update per channel: +1 on accepted write only, -1 on pop only, unchanged when both occur. Count never exceeds DEPTH and never wraps below 0.
- Simultaneous read and write:
  - Different channels: fully independent.
  - Same channel, full: both accepted; count stays DEPTH.
- FWFT = 1:
  - rd_data = head flit of rd_vc, combinational, whenever !empty[rd_vc]; otherwise 0.
  - rd_valid = !empty[rd_vc], combinational.
  - rd_en pops the displayed flit; zero latency.
- FWFT = 0:
  - An accepted pop registers the head flit into rd_data on the same edge; rd_valid = 1 for exactly the following cycle.
  - rd_data holds its last value otherwise.
  - Back-to-back pops give one flit per cycle.
- Out-of-range wr_vc or rd_vc (possible only when NUM_VC is not a power of two) is treated as rejected and flagged via wr_err / rd_err.

Decomposition:
- Package noc_fifo_pkg holds:
  - function clog2_min1
  - typedef flit_t (logic [DATA_WIDTH-1:0] via a parametrised width constant)
  - localparams VC_W and CNT_W
- Sub-module fifo_channel: single-channel storage with pointers, count and flags, plus push/pop inputs and a head output. Instantiated NUM_VC times in a generate loop.
- vc_fifo itself contains: push/pop decode, head mux, FWFT/registered output stage, and the error registers.

Test Plan:
(All with DATA_WIDTH=16, DEPTH=4, NUM_VC=2, AF_THRESH=3 unless stated.)
1. Reset, then write 0x0001..0x0004 to VC0 -> count0 = 1,2,3,4; almost_full[0] rises at count 3; full[0] = 1 at 4; VC1 stays empty; a 5th write gives wr_err = 1 for one cycle, and count0 stays 4.
2. VC0 holds 0x0001..0x0004 (full); in one cycle write 0x0005 to VC0 and pop VC0 -> no wr_err, count0 = 4; subsequent pops return 0x0002, 0x0003, 0x0004, 0x0005 (wrap-around check).
3. Interleave writes VC0 = 0xA0, VC1 = 0xB0, VC0 = 0xA1; pop VC1 then VC0 twice -> 0xB0, 0xA0, 0xA1; per-VC ordering is preserved.
4. Pop VC1 while empty, with a same-cycle write of 0x00C0 to VC1 -> rd_err = 1 next cycle, count1 = 1; the next pop returns 0x00C0.
5. FWFT = 0: write 0x1234, 0x5678 to VC0, then two consecutive pops -> rd_valid is high for 2 cycles, starting one cycle after the first pop, with rd_data = 0x1234 then 0x5678.
6. VC0 at count 3; assert rst = 0 asynchronously mid-cycle -> all outputs return to reset values immediately; after release, writing 0x0009 and popping returns 0x0009.
